// File: rtl/button_pkg.sv
// Shared constants and FSM encoding for the front-panel button conditioner.
// The auto-repeat feature is enabled by defining BUTTON_AUTOREPEAT_EN.
package button_pkg;

  localparam int NUM_BTN  = 4;
  localparam int BTN_SET  = 0;
  localparam int BTN_INCR = 1;
  localparam int BTN_DCR  = 2;
  localparam int BTN_DATE = 3;

  // Only incr/dcr are allowed to auto-repeat.
  localparam logic [NUM_BTN-1:0] REPEAT_MASK = NUM_BTN'((1 << BTN_INCR) | (1 << BTN_DCR));

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } btn_state_e;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchronizer, debounce counter and press/hold FSM.
// With BUTTON_AUTOREPEAT_EN defined, REPEAT_ALLOWED channels emit repeat pulses.
module btn_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000,
`ifdef BUTTON_AUTOREPEAT_EN
  parameter int REPEAT_DELAY    = 2000000,
  parameter int REPEAT_RATE     = 500000,
`endif
  parameter bit REPEAT_ALLOWED  = 1'b0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       raw,
`ifdef BUTTON_AUTOREPEAT_EN
  input  logic       inhibit,
`endif
  output logic       level,
  output logic       pulse,
  output btn_state_e state
);

  localparam int              DB_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync_q1, sync_q2;
  logic [DB_W-1:0] db_cnt, db_cnt_next;
  logic            level_next;
  logic            pulse_next;
  btn_state_e      state_next;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  // Count consecutive synchronized samples that disagree with the accepted level.
  always_comb begin
    level_next  = level;
    db_cnt_next = '0;
    if (sync_q2 != level) begin
      if (db_cnt == DB_LAST) begin
        level_next = ~level;
      end else begin
        db_cnt_next = db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      db_cnt <= '0;
      level  <= 1'b0;
      pulse  <= 1'b0;
      state  <= ST_IDLE;
    end else begin
      db_cnt <= db_cnt_next;
      level  <= level_next;
      pulse  <= pulse_next;
      state  <= state_next;
    end
  end

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int                HOLD_W     = cnt_width(max_int(REPEAT_DELAY, REPEAT_RATE));
  localparam logic [HOLD_W-1:0] DELAY_LAST = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] RATE_LAST  = HOLD_W'(REPEAT_RATE - 1);

  logic [HOLD_W-1:0] hold_cnt, hold_cnt_next;
  logic [HOLD_W-1:0] hold_cnt_inc;

  assign hold_cnt_inc = (&hold_cnt) ? hold_cnt : hold_cnt + 1'b1;

  // Level edges take priority; the conflict inhibit parks the channel in HELD.
  always_comb begin
    state_next    = state;
    hold_cnt_next = hold_cnt;
    pulse_next    = 1'b0;
    if (level && !level_next) begin
      state_next    = ST_IDLE;
      hold_cnt_next = '0;
    end else if (!level && level_next) begin
      state_next    = ST_HELD;
      hold_cnt_next = '0;
      pulse_next    = 1'b1;
    end else begin
      case (state)
        ST_HELD: begin
          if (inhibit) begin
            hold_cnt_next = '0;
          end else if (REPEAT_ALLOWED && hold_cnt == DELAY_LAST) begin
            state_next    = ST_REPEAT;
            hold_cnt_next = '0;
            pulse_next    = 1'b1;
          end else begin
            hold_cnt_next = hold_cnt_inc;
          end
        end
        ST_REPEAT: begin
          if (inhibit) begin
            state_next    = ST_HELD;
            hold_cnt_next = '0;
          end else if (hold_cnt == RATE_LAST) begin
            hold_cnt_next = '0;
            pulse_next    = 1'b1;
          end else begin
            hold_cnt_next = hold_cnt_inc;
          end
        end
        default: hold_cnt_next = '0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_cnt_next;
    end
  end
`else
  always_comb begin
    state_next = state;
    pulse_next = 1'b0;
    if (level && !level_next) begin
      state_next = ST_IDLE;
    end else if (!level && level_next) begin
      state_next = ST_HELD;
      pulse_next = 1'b1;
    end
  end
`endif

  no_repeat_on_fixed: assert property (@(posedge clock) disable iff (!reset_n)
    REPEAT_ALLOWED || state != ST_REPEAT);

endmodule

// File: rtl/button_conditioner.sv
// Four-button conditioner (set/incr/dcr/date) feeding the clock core.
// Define BUTTON_AUTOREPEAT_EN to enable hold-to-repeat on incr and dcr.
module button_conditioner
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int REPEAT_DELAY    = 2000000,
  parameter int REPEAT_RATE     = 500000
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic [NUM_BTN-1:0] repeating
);

  localparam bit CFG_OK = (DEBOUNCE_CYCLES >= 1) && (REPEAT_DELAY >= 1) && (REPEAT_RATE >= 1);

  btn_state_e chan_state [NUM_BTN];

`ifdef BUTTON_AUTOREPEAT_EN
  // Holding incr and dcr together is treated as a conflict: no repeats on either.
  logic conflict;
  assign conflict = btn_level[BTN_INCR] & btn_level[BTN_DCR];
`endif

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
`ifdef BUTTON_AUTOREPEAT_EN
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE),
`endif
      .REPEAT_ALLOWED  (REPEAT_MASK[i])
    ) u_chan (
      .clock   (clock),
      .reset_n (reset_n),
      .raw     (btn_raw[i]),
`ifdef BUTTON_AUTOREPEAT_EN
      .inhibit (REPEAT_MASK[i] & conflict),
`endif
      .level   (btn_level[i]),
      .pulse   (btn_pulse[i]),
      .state   (chan_state[i])
    );

    level_matches_state: assert property (@(posedge clock) disable iff (!reset_n)
      (chan_state[i] != ST_IDLE) == btn_level[i]);
  end

`ifdef BUTTON_AUTOREPEAT_EN
  always_comb begin
    repeating = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      repeating[i] = (chan_state[i] == ST_REPEAT);
    end
  end
`else
  assign repeating = '0;
`endif

  cfg_valid: assert property (@(posedge clock) CFG_OK);
  fixed_chan_no_repeat: assert property (@(posedge clock)
    !repeating[BTN_SET] && !repeating[BTN_DATE]);

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random button traffic
// checked cycle by cycle against a window-based reference model.
module tb_button_conditioner;
  import button_pkg::*;

  localparam int DB   = 4;
  localparam int RD   = 8;
  localparam int RR   = 3;
  localparam int MAXE = 8192;
`ifdef BUTTON_AUTOREPEAT_EN
  localparam bit AUTO_REP = 1'b1;
`else
  localparam bit AUTO_REP = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] btn_raw;
  logic [3:0] btn_level, btn_pulse, repeating;

  button_conditioner #(
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_RATE     (RR)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .btn_pulse (btn_pulse),
    .repeating (repeating)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: raw value sampled at each edge, modelled level after each edge.
  logic [3:0]  samp     [MAXE];
  logic [3:0]  lvl_hist [MAXE];
  int          anchor   [4];
  int          edge_n;
  logic [11:0] exp_q [$];

  int pulse_tally [4];
  int rep_tally   [4];
  int level_tally [4];
  int first_pulse [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic sample_of(input int e, input int c);
    if (e < 0) return 1'b0;
    return samp[e][c];
  endfunction

  // Level flips once the last DB synchronized samples (raw seen 2..DB+1 edges ago)
  // all disagree with it; repeats fall on anchor+RD, +RR, ... while held without conflict.
  task automatic model_edge();
    logic [3:0] prev, cur, pul, rep;
    logic       inh, can_rep;
    bit         flip;
    samp[edge_n] = btn_raw;
    prev = (edge_n == 0) ? 4'b0 : lvl_hist[edge_n-1];
    inh  = AUTO_REP && prev[BTN_INCR] && prev[BTN_DCR];
    for (int c = 0; c < 4; c++) begin
      flip = 1'b1;
      for (int k = 2; k <= DB + 1; k++) begin
        if (sample_of(edge_n - k, c) == prev[c]) flip = 1'b0;
      end
      cur[c]  = prev[c] ^ flip;
      pul[c]  = 1'b0;
      rep[c]  = 1'b0;
      can_rep = AUTO_REP && (c == BTN_INCR || c == BTN_DCR);
      if (cur[c] && !prev[c]) begin
        pul[c]    = 1'b1;
        anchor[c] = edge_n;
      end else if (cur[c] && prev[c] && can_rep) begin
        if (inh) begin
          anchor[c] = edge_n;
        end else begin
          if (edge_n - anchor[c] >= RD && (edge_n - anchor[c] - RD) % RR == 0) pul[c] = 1'b1;
          rep[c] = (edge_n - anchor[c] >= RD);
        end
      end
    end
    lvl_hist[edge_n] = cur;
    exp_q.push_back({rep, pul, cur});
    edge_n++;
  endtask

  task automatic model_reset();
    edge_n = 0;
    exp_q.delete();
    for (int c = 0; c < 4; c++) begin
      anchor[c]      = 0;
      pulse_tally[c] = 0;
      rep_tally[c]   = 0;
      level_tally[c] = 0;
      first_pulse[c] = -1;
    end
  endtask

  task automatic step();
    logic [11:0] e;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    e = exp_q.pop_front();
    check("level", 32'(btn_level), 32'(e[3:0]));
    check("pulse", 32'(btn_pulse), 32'(e[7:4]));
    check("repeating", 32'(repeating), 32'(e[11:8]));
    for (int c = 0; c < 4; c++) begin
      pulse_tally[c] += int'(btn_pulse[c]);
      rep_tally[c]   += int'(repeating[c]);
      level_tally[c] += int'(btn_level[c]);
      if (btn_pulse[c] && first_pulse[c] < 0) first_pulse[c] = edge_n - 1;
    end
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("rst_level", 32'(btn_level), 32'h0);
    check("rst_pulse", 32'(btn_pulse), 32'h0);
    check("rst_repeating", 32'(repeating), 32'h0);
    @(negedge clock);
    model_reset();
    reset_n = 1'b1;
  endtask

  task automatic hold(input logic [3:0] mask, input int cycles);
    btn_raw = mask;
    repeat (cycles) step();
    btn_raw = 4'b0;
    repeat (12) step();
  endtask

  int dwell [4];

  initial begin
    reset_n = 1'b0;
    btn_raw = 4'b0;
    model_reset();

    // Clean press on set: pulse after edge 5, level high for 20 cycles.
    apply_reset();
    hold(4'b0001, 20);
    check("set_pulses", 32'(pulse_tally[0]), 32'd1);
    check("set_latency", 32'(first_pulse[0]), 32'd5);
    check("set_level_len", 32'(level_tally[0]), 32'd20);

    // Glitch of 3 samples on incr is rejected.
    apply_reset();
    hold(4'b0010, 3);
    check("glitch_pulses", 32'(pulse_tally[1]), 32'd0);
    check("glitch_level", 32'(level_tally[1]), 32'd0);

    // Incr held 30 cycles: press at 5, repeats at 13,16,...,34.
    apply_reset();
    hold(4'b0010, 30);
    check("incr_pulses", 32'(pulse_tally[1]), AUTO_REP ? 32'd9 : 32'd1);
    check("incr_latency", 32'(first_pulse[1]), 32'd5);
    check("incr_rep_len", 32'(rep_tally[1]), AUTO_REP ? 32'd22 : 32'd0);

    // Incr and dcr together: only the two press pulses.
    apply_reset();
    hold(4'b0110, 30);
    check("conf_incr_pulses", 32'(pulse_tally[1]), 32'd1);
    check("conf_dcr_pulses", 32'(pulse_tally[2]), 32'd1);
    check("conf_rep", 32'(rep_tally[1] + rep_tally[2]), 32'd0);

    // Date never repeats.
    apply_reset();
    hold(4'b1000, 30);
    check("date_pulses", 32'(pulse_tally[3]), 32'd1);
    check("date_rep", 32'(rep_tally[3]), 32'd0);

    // Reset in the middle of a repeat train, button still held across it.
    apply_reset();
    btn_raw = 4'b0010;
    repeat (18) step();
    check("pre_rst_rep", 32'(repeating[1]), AUTO_REP ? 32'd1 : 32'd0);
    apply_reset();
    repeat (10) step();
    check("post_rst_latency", 32'(first_pulse[1]), 32'd5);
    check("post_rst_pulses", 32'(pulse_tally[1]), 32'd1);
    btn_raw = 4'b0;
    repeat (12) step();

    // Random traffic: mixes glitches and long holds on all four channels.
    apply_reset();
    for (int c = 0; c < 4; c++) dwell[c] = $urandom_range(1, 40);
    repeat (2000) begin
      for (int c = 0; c < 4; c++) begin
        if (dwell[c] == 0) begin
          btn_raw[c] = ~btn_raw[c];
          dwell[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DB) : $urandom_range(DB + 1, 40);
        end else begin
          dwell[c]--;
        end
      end
      step();
    end
    btn_raw = 4'b0;
    repeat (20) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
